// File: rtl/water_pump_ctrl.sv
// Water pump controller: reads a thermometer-coded stack of level sensors,
// runs the lead pump or all pumps depending on the water level, enforces a
// minimum run time, and latches a fault on persistent illegal sensor codes.
// Optional feature: define PUMP_ALTERNATE_EN to rotate the lead pump after
// every completed run; otherwise pump 0 is always the lead.
module water_pump_ctrl #(
   parameter int NUM_SENSORS   = 4,
   parameter int NUM_PUMPS     = 2,
   parameter int MIN_ON_CYCLES = 8,
   localparam int LW = $clog2(NUM_SENSORS + 1),
   localparam int PW = (NUM_PUMPS > 1) ? $clog2(NUM_PUMPS) : 1
) (
   input  logic                   Clock,
   input  logic                   Reset,
   input  logic [NUM_SENSORS-1:0] S,
   input  logic                   fault_clr,
   output logic [NUM_PUMPS-1:0]   B,
   output logic                   fault,
   output logic [LW-1:0]          level,
   output logic [PW-1:0]          lead
);

   typedef enum logic [1:0] {IDLE, RUN_LEAD, RUN_ALL, FAULT} state_t;

   localparam logic [7:0]    MIN_CNT = 8'(MIN_ON_CYCLES);
   localparam logic [LW-1:0] LVL_FULL = LW'(NUM_SENSORS);

   state_t                 state;
   state_t                 state_nxt;
   logic [7:0]             run_cnt;
   logic [7:0]             cnt_inc;
   logic                   inv_flag;
   logic                   valid;
   logic [NUM_SENSORS:0]   s_ext;
   logic [LW-1:0]          ones;
   logic [LW-1:0]          lvl_eval;
   logic                   done;
   logic [PW-1:0]          lead_nxt;
   logic [NUM_PUMPS-1:0]   b_nxt;

   assign s_ext = {1'b0, S};

   // Pattern check and popcount of the current sample; invalid samples keep the old level
   always_comb begin
      valid = (((s_ext + 1'b1) & s_ext) == '0);
      ones  = '0;
      for (int i = 0; i < NUM_SENSORS; i++) begin
         ones = ones + LW'(S[i]);
      end
      lvl_eval = valid ? ones : level;
   end

   // Run counter saturates at the minimum run time; a full tank only stops
   // the pumps once the counter value for this edge has reached it
   assign cnt_inc = (run_cnt >= MIN_CNT) ? MIN_CNT : run_cnt + 8'd1;
   assign done    = (lvl_eval == LVL_FULL) && (cnt_inc >= MIN_CNT);

   // Next-state selection: persistent invalid code beats everything, a single
   // invalid sample freezes the state, then fault clear, then level tracking
   always_comb begin
      state_nxt = state;
      if (!valid && inv_flag) begin
         state_nxt = FAULT;
      end else if (valid) begin
         case (state)
            IDLE: begin
               if (lvl_eval == '0)           state_nxt = RUN_ALL;
               else if (lvl_eval == LW'(1))  state_nxt = RUN_LEAD;
            end
            RUN_LEAD: begin
               if (lvl_eval == '0)           state_nxt = RUN_ALL;
               else if (done)                state_nxt = IDLE;
            end
            RUN_ALL: begin
               if (lvl_eval >= LW'(2) && lvl_eval < LVL_FULL) state_nxt = RUN_LEAD;
               else if (done)                state_nxt = IDLE;
            end
            FAULT: begin
               if (fault_clr)                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

`ifdef PUMP_ALTERNATE_EN
   logic run_to_idle;
   assign run_to_idle = ((state == RUN_LEAD) || (state == RUN_ALL)) && (state_nxt == IDLE);

   // Lead advances round-robin each time a pumping run completes
   always_comb begin
      lead_nxt = lead;
      if (run_to_idle) begin
         lead_nxt = (lead == PW'(NUM_PUMPS - 1)) ? '0 : lead + PW'(1);
      end
   end
`else
   assign lead_nxt = '0;
   assign lead     = '0;
`endif

   // Pump enables derived from the state being entered
   always_comb begin
      case (state_nxt)
         RUN_LEAD: b_nxt = NUM_PUMPS'(1) << lead_nxt;
         RUN_ALL:  b_nxt = '1;
         default:  b_nxt = '0;
      endcase
   end

   // Controller state and registered outputs
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         B        <= '0;
         fault    <= 1'b0;
         level    <= '0;
         run_cnt  <= '0;
         inv_flag <= 1'b0;
`ifdef PUMP_ALTERNATE_EN
         lead     <= '0;
`endif
      end else begin
         state    <= state_nxt;
         B        <= b_nxt;
         fault    <= (state_nxt == FAULT);
         level    <= lvl_eval;
         inv_flag <= !valid;
         if (state == RUN_LEAD || state == RUN_ALL) run_cnt <= cnt_inc;
         else                                       run_cnt <= '0;
`ifdef PUMP_ALTERNATE_EN
         lead     <= lead_nxt;
`endif
      end
   end

endmodule
